// File: rtl/bus_responder.sv
// ---------------------------------------------------------------------------
// bus_responder
//   Memory/IO target on the 8085 multiplexed address/data bus. Answers the
//   M1 (opcode fetch), memory read and memory write machine cycles issued by
//   the CPU sequencer: latches A15..A0 while ALE is high, decodes a memory
//   window, inserts WAIT_STATES wait cycles through ready, then drives read
//   data onto AD or commits write data from AD into an internal byte array.
//
// Optional feature (compile-time macro RESP_IO_EN):
//   defined   - IO cycles (iomn=1) also decode; a 4 x 8 port register file is
//               hit when addr[7:2] == IO_BASE[7:2], indexed by addr[1:0].
//   undefined - IO cycles never hit; no port registers exist.
//
// Ports
//   phi1        in   system clock, everything samples on the rising edge
//   reset       in   asynchronous active-high reset
//   ale         in   address latch enable
//   ad_in[7:0]  in   AD7..AD0 as driven by the CPU (low address / write data)
//   a_hi[7:0]   in   A15..A8
//   iomn        in   1 = IO cycle, 0 = memory cycle
//   s1, s0      in   status: 11 opcode fetch, 10 read, 01 write
//   rdn, wrn    in   read / write strobes, active low
//   ad_out[7:0] out  read data for the AD bus
//   ad_oe       out  AD output enable for the external tri-state buffer
//   ready       out  0 = insert a wait state
//   hit         out  current cycle addresses this block
//   opfetch     out  current cycle was latched as an opcode fetch
//   bus_err     out  sticky: rdn and wrn seen low together on a hit
//   o_dbg_state out  current FSM state (debug visibility)
//
// Bus handshake: a cycle starts on any edge with ale=1 and is armed once hit
// is decoded. The first edge that sees hit=1 and exactly one strobe low
// accepts the transfer. ready is low for exactly WAIT_STATES cycles after
// acceptance; read data is then driven while rdn stays low and the bus is
// released combinationally when rdn rises. Write data is captured on every
// edge with wrn low and committed on the first edge with wrn high. ale high
// on any edge aborts whatever is in flight without driving or writing.
// ---------------------------------------------------------------------------
module bus_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  IO_BASE     = 8'h40
) (
  input  logic       phi1,
  input  logic       reset,
  input  logic       ale,
  input  logic [7:0] ad_in,
  input  logic [7:0] a_hi,
  input  logic       iomn,
  input  logic       s1,
  input  logic       s0,
  input  logic       rdn,
  input  logic       wrn,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ready,
  output logic       hit,
  output logic       opfetch,
  output logic       bus_err,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RDDRV = 3'd3,
    ST_WRCAP = 3'd4
  } state_t;

  localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);
`ifdef RESP_IO_EN
  localparam logic LP_IO_EN = 1'b1;
`else
  localparam logic LP_IO_EN = 1'b0;
`endif

  state_t      r_state;
  logic [15:0] r_addr;
  logic        r_hit;
  logic        r_opfetch;
  logic        r_bus_err;
  logic        r_is_rd;
  logic [2:0]  r_wcnt;
  logic [7:0]  r_wdata;
  logic [7:0]  r_ad_out;

  // Memory is deliberately outside the reset domain: contents survive reset.
  logic [7:0]  r_mem [2**ADDR_BITS];

`ifdef RESP_IO_EN
  logic        r_is_io;
  logic [7:0]  r_port [4];
`endif

  logic                 w_mem_match;
  logic                 w_io_match;
  logic                 w_decode;
  logic                 w_rd_req;
  logic                 w_wr_req;
  logic                 w_both;
  logic                 w_io_cycle;
  logic                 w_commit;
  logic [ADDR_BITS-1:0] w_mem_idx;
  logic [7:0]           w_rd_data;

  // Only the bits above the window size take part in the memory decode, so
  // every address inside the window wraps onto the low ADDR_BITS index.
  assign w_mem_match = (r_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign w_io_match  = (r_addr[7:2] == IO_BASE[7:2]);
  assign w_decode    = iomn ? (LP_IO_EN & w_io_match) : w_mem_match;

  assign w_rd_req  = ~rdn &  wrn;
  assign w_wr_req  =  rdn & ~wrn;
  assign w_both    = ~rdn & ~wrn;
  assign w_mem_idx = r_addr[ADDR_BITS-1:0];

`ifdef RESP_IO_EN
  assign w_io_cycle = r_is_io;
  assign w_rd_data  = r_is_io ? r_port[r_addr[1:0]] : r_mem[w_mem_idx];
`else
  assign w_io_cycle = 1'b0;
  assign w_rd_data  = r_mem[w_mem_idx];
`endif

  // Commit happens on the first edge with wrn high in WRCAP; an ALE on the
  // same edge wins and the write is dropped.
  assign w_commit = (r_state == ST_WRCAP) & wrn & ~ale;

  always_ff @(posedge phi1) begin
    if (w_commit && !w_io_cycle) begin
      r_mem[w_mem_idx] <= r_wdata;
    end
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= 16'h0000;
      r_hit     <= 1'b0;
      r_opfetch <= 1'b0;
      r_bus_err <= 1'b0;
      r_is_rd   <= 1'b0;
      r_wcnt    <= 3'd0;
      r_wdata   <= 8'h00;
      r_ad_out  <= 8'h00;
`ifdef RESP_IO_EN
      r_is_io   <= 1'b0;
      for (int i = 0; i < 4; i++) r_port[i] <= 8'h00;
`endif
    end else if (ale) begin
      r_state   <= ST_ADDR;
      r_addr    <= {a_hi, ad_in};
      r_opfetch <= s1 & s0;
      r_hit     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end

        ST_ADDR: begin
          // Decode keeps refreshing while armed; the address is stable, so
          // hit stays put once set.
          r_hit <= w_decode;
`ifdef RESP_IO_EN
          r_is_io <= iomn;
`endif
          if (r_hit) begin
            if (w_both) begin
              r_bus_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (w_rd_req || w_wr_req) begin
              r_is_rd <= w_rd_req;
              r_wdata <= ad_in;
              r_wcnt  <= LP_WAIT;
              if (LP_WAIT == 3'd0) begin
                if (w_rd_req) begin
                  r_state  <= ST_RDDRV;
                  r_ad_out <= w_rd_data;
                end else begin
                  r_state  <= ST_WRCAP;
                end
              end else begin
                r_state <= ST_WAIT;
              end
            end
          end
        end

        ST_WAIT: begin
          if (w_both) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            if (!wrn) r_wdata <= ad_in;
            r_wcnt <= r_wcnt - 3'd1;
            if (r_wcnt == 3'd1) begin
              if (r_is_rd) begin
                r_state  <= ST_RDDRV;
                r_ad_out <= w_rd_data;
              end else begin
                r_state  <= ST_WRCAP;
              end
            end
          end
        end

        ST_RDDRV: begin
          if (w_both) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_ad_out <= w_rd_data;
            if (rdn) r_state <= ST_IDLE;
          end
        end

        ST_WRCAP: begin
          if (w_both) begin
            r_bus_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (!wrn) begin
            r_wdata <= ad_in;
          end else begin
`ifdef RESP_IO_EN
            if (r_is_io) r_port[r_addr[1:0]] <= r_wdata;
`endif
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ready and ad_oe follow the state register directly so that reset and
  // the rising edge of rdn release the bus without waiting for a clock.
  assign ready       = (r_state != ST_WAIT);
  assign ad_oe       = (r_state == ST_RDDRV) & ~rdn;
  assign ad_out      = r_ad_out;
  assign hit         = r_hit;
  assign opfetch     = r_opfetch;
  assign bus_err     = r_bus_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_responder
//   Three responders share one CPU bus:
//     d=0 : window 0x0000-0x00FF, no wait states
//     d=1 : window 0x0000-0x00FF, two wait states
//     d=2 : window 0x8000-0x80FF, one wait state
//   A reference model (sparse byte memory per responder, IO port file,
//   sticky error flag) predicts hit, ready, ad_oe, ad_out and bus_err for
//   every sampled cycle from the address window and wait-state count.
// ---------------------------------------------------------------------------
module tb_bus_responder;

  localparam int AB = 8;

  // ---------------- clock / reset ----------------
  logic       phi1 = 1'b0;
  logic       reset;
  logic       ale;
  logic [7:0] ad_in;
  logic [7:0] a_hi;
  logic       iomn;
  logic       s1;
  logic       s0;
  logic       rdn;
  logic       wrn;

  logic [7:0] ad_out [3];
  logic [2:0] ad_oe;
  logic [2:0] ready;
  logic [2:0] hit;
  logic [2:0] opfetch;
  logic [2:0] bus_err;
  logic [2:0] dbg_state [3];

  always #5 phi1 = ~phi1;

  bus_responder #(.ADDR_BITS(AB), .BASE_ADDR(16'h0000), .WAIT_STATES(0), .IO_BASE(8'h40)) u_ws0 (
    .phi1(phi1), .reset(reset), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .iomn(iomn),
    .s1(s1), .s0(s0), .rdn(rdn), .wrn(wrn), .ad_out(ad_out[0]), .ad_oe(ad_oe[0]),
    .ready(ready[0]), .hit(hit[0]), .opfetch(opfetch[0]), .bus_err(bus_err[0]),
    .o_dbg_state(dbg_state[0])
  );

  bus_responder #(.ADDR_BITS(AB), .BASE_ADDR(16'h0000), .WAIT_STATES(2), .IO_BASE(8'h40)) u_ws2 (
    .phi1(phi1), .reset(reset), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .iomn(iomn),
    .s1(s1), .s0(s0), .rdn(rdn), .wrn(wrn), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]),
    .ready(ready[1]), .hit(hit[1]), .opfetch(opfetch[1]), .bus_err(bus_err[1]),
    .o_dbg_state(dbg_state[1])
  );

  bus_responder #(.ADDR_BITS(AB), .BASE_ADDR(16'h8000), .WAIT_STATES(1), .IO_BASE(8'h40)) u_hi (
    .phi1(phi1), .reset(reset), .ale(ale), .ad_in(ad_in), .a_hi(a_hi), .iomn(iomn),
    .s1(s1), .s0(s0), .rdn(rdn), .wrn(wrn), .ad_out(ad_out[2]), .ad_oe(ad_oe[2]),
    .ready(ready[2]), .hit(hit[2]), .opfetch(opfetch[2]), .bus_err(bus_err[2]),
    .o_dbg_state(dbg_state[2])
  );

  // ---------------- reference model ----------------
  int          ws_p   [3] = '{0, 2, 1};
  logic [15:0] base_p [3] = '{16'h0000, 16'h0000, 16'h8000};
  logic [7:0]  mdl [int];          // key = d*65536 + byte index
  logic [7:0]  pmdl [3][4];
  logic        err_m [3];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic exp_hit(int d, logic [15:0] a, logic io);
    int lo;
    if (io) begin
`ifdef RESP_IO_EN
      return (a[7:0] >= 8'h40) && (a[7:0] <= 8'h43);
`else
      return 1'b0;
`endif
    end
    lo = (int'(base_p[d]) / (1 << AB)) * (1 << AB);
    return (int'(a) >= lo) && (int'(a) < lo + (1 << AB));
  endfunction

  function automatic int mkey(int d, logic [15:0] a);
    return d * 65536 + (int'(a) % (1 << AB));
  endfunction

  task automatic lookup(input int d, input logic [15:0] a, input logic io,
                        output logic known, output logic [7:0] val);
    known = 1'b0;
    val   = 8'h00;
    if (io) begin
      known = 1'b1;
      val   = pmdl[d][a[1:0]];
    end else if (mdl.exists(mkey(d, a))) begin
      known = 1'b1;
      val   = mdl[mkey(d, a)];
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      err_m[d] = 1'b0;
      for (int p = 0; p < 4; p++) pmdl[d][p] = 8'h00;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // kind: 0 = memory/IO read, 1 = write, 2 = opcode fetch
  task automatic bus_cycle(input logic [15:0] a, input logic io, input int kind,
                           input logic [7:0] wd, input int hold);
    logic       h [3];
    logic       known;
    logic [7:0] val;
    ale   = 1'b1;
    a_hi  = a[15:8];
    ad_in = a[7:0];
    iomn  = io;
    {s1, s0} = (kind == 2) ? 2'b11 : (kind == 1) ? 2'b01 : 2'b10;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("ale_hit", d, 8'(hit[d]), 8'h00);
      chk("ale_opf", d, 8'(opfetch[d]), 8'(kind == 2));
      chk("ale_rdy", d, 8'(ready[d]), 8'h01);
    end
    ale   = 1'b0;
    ad_in = (kind == 1) ? wd : 8'($urandom);
    tick();
    for (int d = 0; d < 3; d++) begin
      h[d] = exp_hit(d, a, io);
      chk("dec_hit", d, 8'(hit[d]), 8'(h[d]));
    end
    if (kind == 1) wrn = 1'b0;
    else           rdn = 1'b0;
    for (int n = 0; n < hold; n++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        if (h[d]) begin
          chk("strb_rdy", d, 8'(ready[d]), 8'(n >= ws_p[d]));
          chk("strb_oe", d, 8'(ad_oe[d]), 8'((kind != 1) && (n >= ws_p[d])));
          lookup(d, a, io, known, val);
          if (kind != 1 && n >= ws_p[d] && known) chk("rd_data", d, ad_out[d], val);
        end else begin
          chk("miss_rdy", d, 8'(ready[d]), 8'h01);
          chk("miss_oe", d, 8'(ad_oe[d]), 8'h00);
        end
      end
    end
    rdn = 1'b1;
    wrn = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk("rel_oe", d, 8'(ad_oe[d]), 8'h00);
    tick();
    for (int d = 0; d < 3; d++) begin
      if (kind == 1 && h[d]) begin
        if (io) pmdl[d][a[1:0]] = wd;
        else    mdl[mkey(d, a)] = wd;
      end
      chk("end_rdy", d, 8'(ready[d]), 8'h01);
      chk("end_err", d, 8'(bus_err[d]), 8'(err_m[d]));
    end
  endtask

  task automatic err_cycle(input logic [15:0] a);
    ale = 1'b1; a_hi = a[15:8]; ad_in = a[7:0]; iomn = 1'b0; {s1, s0} = 2'b10;
    tick();
    ale = 1'b0; ad_in = 8'hC3;
    tick();
    rdn = 1'b0; wrn = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      if (exp_hit(d, a, 1'b0)) err_m[d] = 1'b1;
      chk("err_flag", d, 8'(bus_err[d]), 8'(err_m[d]));
      chk("err_oe", d, 8'(ad_oe[d]), 8'h00);
      chk("err_rdy", d, 8'(ready[d]), 8'h01);
    end
    rdn = 1'b1; wrn = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra;
    logic        rio;
    reset = 1'b1; ale = 1'b0; ad_in = 8'h00; a_hi = 8'h00; iomn = 1'b0;
    s1 = 1'b0; s0 = 1'b0; rdn = 1'b1; wrn = 1'b1;
    model_reset();
    repeat (2) @(posedge phi1);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_dout", d, ad_out[d], 8'h00);
      chk("rst_oe", d, 8'(ad_oe[d]), 8'h00);
      chk("rst_rdy", d, 8'(ready[d]), 8'h01);
      chk("rst_hit", d, 8'(hit[d]), 8'h00);
      chk("rst_opf", d, 8'(opfetch[d]), 8'h00);
      chk("rst_err", d, 8'(bus_err[d]), 8'h00);
    end
    reset = 1'b0;
    tick();

    // write/read in both windows, a miss, and an opcode fetch
    bus_cycle(16'h0012, 1'b0, 1, 8'hA5, 4);
    bus_cycle(16'h0012, 1'b0, 0, 8'h00, 4);
    bus_cycle(16'h8012, 1'b0, 1, 8'h5A, 3);
    bus_cycle(16'h8012, 1'b0, 0, 8'h00, 3);
    bus_cycle(16'h8112, 1'b0, 0, 8'h00, 3);
    bus_cycle(16'h0012, 1'b0, 2, 8'h00, 5);

    // both strobes low: sticky error, memory untouched
    err_cycle(16'h0012);
    bus_cycle(16'h0012, 1'b0, 0, 8'h00, 3);

    // ALE during an accepted write aborts it
    ale = 1'b1; a_hi = 8'h00; ad_in = 8'h12; iomn = 1'b0; {s1, s0} = 2'b01;
    tick();
    ale = 1'b0; ad_in = 8'hEE;
    tick();
    wrn = 1'b0;
    tick();
    wrn = 1'b1; ale = 1'b1; a_hi = 8'h00; ad_in = 8'h13; {s1, s0} = 2'b10;
    tick();
    ale = 1'b0;
    tick();
    bus_cycle(16'h0012, 1'b0, 0, 8'h00, 3);

    // reset during the wait of a write of 8'h3C
    ale = 1'b1; a_hi = 8'h00; ad_in = 8'h12; iomn = 1'b0; {s1, s0} = 2'b01;
    tick();
    ale = 1'b0; ad_in = 8'h3C;
    tick();
    wrn = 1'b0;
    tick();
    chk("wait_rdy", 1, 8'(ready[1]), 8'h00);
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      chk("arst_rdy", d, 8'(ready[d]), 8'h01);
      chk("arst_oe", d, 8'(ad_oe[d]), 8'h00);
      chk("arst_err", d, 8'(bus_err[d]), 8'h00);
    end
    tick();
    wrn = 1'b1;
    reset = 1'b0;
    tick();
    bus_cycle(16'h0012, 1'b0, 0, 8'h00, 3);

    // IO write then read of port 0x42
    bus_cycle(16'h4242, 1'b1, 1, 8'h77, 3);
    bus_cycle(16'h4242, 1'b1, 0, 8'h00, 3);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rio = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       ra[15:8] = 8'h00;
        1:       ra[15:8] = 8'h80;
        2:       ra[15:8] = 8'h81;
        default: ra[15:8] = 8'($urandom);
      endcase
      ra[7:0] = rio ? 8'(8'h40 + $urandom_range(0, 7)) : 8'(8'h10 + $urandom_range(0, 7));
      bus_cycle(ra, rio, int'($urandom_range(0, 2)), 8'($urandom), int'($urandom_range(3, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
